// File: rtl/rom_loader_pkg.sv
// Shared constants and types for the ROM download router.
package rom_loader_pkg;

  localparam int ADDR_W = 25;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

  typedef enum logic {MODE_TOGGLE, MODE_PULSE} reg_mode_t;

  // One ioctl write, as seen on the edge cycle (or parked in the pending slot).
  typedef struct packed {
    logic              dl;
    logic [7:0]        idx;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } ioctl_ev_t;

endpackage

// File: rtl/rom_region_dec.sv
// One output region: base/limit hit test, relative address and the req/wr register.
module rom_region_dec
  import rom_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE  = '0,
  parameter logic [ADDR_W-1:0] LIMIT = '1,
  parameter reg_mode_t         MODE  = MODE_TOGGLE
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              fire,
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [ADDR_W-1:0] rel,
  output logic [ADDR_W-1:0] rel_q,
  output logic              req,
  output logic              wr
);

  assign hit = (addr >= BASE) && (addr < LIMIT);
  assign rel = addr - BASE;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      req   <= 1'b0;
      wr    <= 1'b0;
      rel_q <= '0;
    end else begin
      wr <= 1'b0;
      if (fire && hit) begin
        if (MODE == MODE_PULSE) wr  <= 1'b1;
        else                    req <= ~req;
        rel_q <= rel;
      end
    end
  end

endmodule

// File: rtl/rom_loader_router.sv
// Fans the HPS ioctl ROM stream out to NREG regions, captures mode/DIP bytes, drives core reset.
// ROM_LOADER_WAIT_EN adds reg_ack/ioctl_wait handshaking with a one-entry pending slot.
module rom_loader_router
  import rom_loader_pkg::*;
#(
  parameter int                     NREG      = 4,
  parameter logic [NREG*ADDR_W-1:0] REG_BASE  = {NREG{25'h0}},
  parameter logic [NREG*ADDR_W-1:0] REG_LIMIT = {NREG{25'h1FFFFFF}},
  parameter logic [NREG-1:0]        REG_MODE  = '0,
  parameter int                     DIP_BYTES = 8,
  parameter logic [15:0]            RST_HOLD  = 16'hFFFF
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      ioctl_download,
  input  logic [7:0]                ioctl_index,
  input  logic                      ioctl_wr,
  input  logic [ADDR_W-1:0]         ioctl_addr,
  input  logic [7:0]                ioctl_dout,
  input  logic                      status_reset,
  input  logic                      button_reset,
  output logic [NREG-1:0]           reg_req,
  output logic [NREG-1:0]           reg_wr,
  output logic [ADDR_W-1:0]         reg_addr,
  output logic [NREG*ADDR_W-1:0]    reg_addr_all,
  output logic [7:0]                reg_data,
  output logic [7:0]                core_mod,
  output logic [8*DIP_BYTES-1:0]    dip,
  output logic                      rom_loaded,
`ifdef ROM_LOADER_WAIT_EN
  input  logic [NREG-1:0]           reg_ack,
  output logic                      ioctl_wait,
`endif
  output logic                      core_reset
);

  logic      wr_last, wr_edge, rom_dl, rom_dl_q, loaded_nxt;
  logic      fire, rom_fire, any_hit;
  ioctl_ev_t cur_ev, ev;
  logic [15:0] cnt;

  logic [NREG-1:0]             hit;
  logic [NREG-1:0][ADDR_W-1:0] rel, rel_q;
  logic [ADDR_W-1:0]           first_rel;
  logic [DIP_BYTES-1:0][7:0]   dip_q;

  assign rom_dl  = ioctl_download && (ioctl_index == IDX_ROM);
  assign wr_edge = ioctl_wr && !wr_last;
  assign cur_ev  = '{dl: ioctl_download, idx: ioctl_index, addr: ioctl_addr, data: ioctl_dout};

`ifdef ROM_LOADER_WAIT_EN
  logic      outstanding, pend_vld, ovf;
  ioctl_ev_t pend;

  // Pulse regions never wait; only toggle regions carry a req/ack handshake.
  assign outstanding = |((reg_req ^ reg_ack) & ~REG_MODE);
  assign ioctl_wait  = outstanding;

  always_comb begin
    fire = 1'b0;
    ev   = cur_ev;
    if (!outstanding) begin
      if (pend_vld) begin
        fire = 1'b1;
        ev   = pend;
      end else begin
        fire = wr_edge;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend_vld <= 1'b0;
      pend     <= '0;
      ovf      <= 1'b0;
    end else if (wr_edge && outstanding && pend_vld) begin
      ovf <= 1'b1;
    end else if (wr_edge && (outstanding || pend_vld)) begin
      pend     <= cur_ev;
      pend_vld <= 1'b1;
    end else if (!outstanding) begin
      pend_vld <= 1'b0;
    end
  end
`else
  assign fire = wr_edge;
  assign ev   = cur_ev;
`endif

  assign rom_fire = fire && ev.dl && (ev.idx == IDX_ROM);

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    rom_region_dec #(
      .BASE  (REG_BASE[i*ADDR_W +: ADDR_W]),
      .LIMIT (REG_LIMIT[i*ADDR_W +: ADDR_W]),
      .MODE  (reg_mode_t'(REG_MODE[i]))
    ) u_dec (
      .clk_sys (clk_sys),
      .reset   (reset),
      .fire    (rom_fire),
      .addr    (ev.addr),
      .hit     (hit[i]),
      .rel     (rel[i]),
      .rel_q   (rel_q[i]),
      .req     (reg_req[i]),
      .wr      (reg_wr[i])
    );
  end

  assign reg_addr_all = rel_q;
  assign dip          = dip_q;
  assign any_hit      = |hit;

  // Shared reg_addr follows the lowest-numbered hit region.
  always_comb begin
    first_rel = rel[0];
    for (int i = NREG - 1; i >= 0; i--)
      if (hit[i]) first_rel = rel[i];
  end

  // Using the next rom_loaded lets the hold start the cycle the download ends.
  assign loaded_nxt = rom_loaded || (rom_dl_q && !rom_dl);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_last    <= 1'b1;
      rom_dl_q   <= 1'b0;
      rom_loaded <= 1'b0;
      reg_data   <= '0;
      reg_addr   <= '0;
      core_mod   <= '0;
      dip_q      <= '0;
      cnt        <= RST_HOLD;
      core_reset <= 1'b1;
    end else begin
      wr_last    <= ioctl_wr;
      rom_dl_q   <= rom_dl;
      rom_loaded <= loaded_nxt;
      if (rom_fire) begin
        reg_data <= ev.data;
        if (any_hit) reg_addr <= first_rel;
      end
      if (fire && ev.idx == IDX_MOD) core_mod <= ev.data;
      for (int k = 0; k < DIP_BYTES; k++)
        if (fire && ev.idx == IDX_DIP && ev.addr == ADDR_W'(k)) dip_q[k] <= ev.data;
      if (status_reset || button_reset || !loaded_nxt || rom_dl) cnt <= RST_HOLD;
      else if (cnt != 16'd0)                                       cnt <= cnt - 16'd1;
      core_reset <= (cnt != 16'd0);
    end
  end

endmodule

// File: tb/tb_rom_loader_router.sv
// Scoreboard bench for rom_loader_router; covers ROM_LOADER_WAIT_EN when that macro is defined.
module tb_rom_loader_router;
  localparam int              NREG  = 3;
  localparam logic [74:0]     BASE  = {25'h20000, 25'h30000, 25'h00000};
  localparam logic [74:0]     LIMIT = {25'h30000, 25'h90000, 25'h90000};
  localparam logic [NREG-1:0] MODE  = 3'b100;

  logic clk_sys = 1'b0;
  logic reset, ioctl_download, ioctl_wr, status_reset, button_reset;
  logic [7:0]  ioctl_index, ioctl_dout, reg_data, core_mod;
  logic [24:0] ioctl_addr, reg_addr;
  logic [NREG-1:0] reg_req, reg_wr;
  logic [74:0] reg_addr_all;
  logic [63:0] dip;
  logic rom_loaded, core_reset;
`ifdef ROM_LOADER_WAIT_EN
  logic [NREG-1:0] reg_ack, ack_man;
  logic ack_auto, ioctl_wait;
  assign reg_ack = ack_auto ? reg_req : ack_man;
`endif

  always #5 clk_sys = ~clk_sys;

  rom_loader_router #(
    .NREG(NREG), .REG_BASE(BASE), .REG_LIMIT(LIMIT), .REG_MODE(MODE),
    .DIP_BYTES(8), .RST_HOLD(16'd16)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .status_reset(status_reset), .button_reset(button_reset),
    .reg_req(reg_req), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_addr_all(reg_addr_all),
    .reg_data(reg_data), .core_mod(core_mod), .dip(dip), .rom_loaded(rom_loaded),
`ifdef ROM_LOADER_WAIT_EN
    .reg_ack(reg_ack), .ioctl_wait(ioctl_wait),
`endif
    .core_reset(core_reset)
  );

  typedef struct {
    logic [NREG-1:0] req, wr;
    logic [74:0]     all;
    logic [24:0]     raddr;
    logic [7:0]      data, cmod;
    logic [63:0]     dip;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_rst();
    m.req = '0; m.wr = '0; m.all = '0; m.raddr = '0;
    m.data = '0; m.cmod = '0; m.dip = '0;
  endtask

  task automatic model_ev(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    logic first;
    first = 1'b1;
    m.wr  = '0;
    if (ioctl_download && idx == 8'd0) begin
      m.data = d;
      for (int i = 0; i < NREG; i++) begin
        if (a >= BASE[i*25 +: 25] && a < LIMIT[i*25 +: 25]) begin
          if (MODE[i]) m.wr[i]  = 1'b1;
          else         m.req[i] = ~m.req[i];
          m.all[i*25 +: 25] = a - BASE[i*25 +: 25];
          if (first) m.raddr = a - BASE[i*25 +: 25];
          first = 1'b0;
        end
      end
    end
    if (idx == 8'd1) m.cmod = d;
    if (idx == 8'd254 && a < 25'd8) m.dip[a[2:0]*8 +: 8] = d;
    sb.push_back(m);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("reg_req", reg_req, e.req);
      chk("reg_wr", reg_wr, e.wr);
      chk("reg_addr_all", reg_addr_all, e.all);
      chk("reg_addr", reg_addr, e.raddr);
      chk("reg_data", reg_data, e.data);
      chk("core_mod", core_mod, e.cmod);
      chk("dip", dip, e.dip);
    end
  endtask

  // Drives one write held for `hold` cycles; returns the number of reg_wr pulses seen.
  task automatic wr_ev(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d,
                       input int hold, input bit do_model, input bit do_check, output int pulses);
    ioctl_index = idx; ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    if (do_model) model_ev(idx, a, d);
    @(posedge clk_sys); #1;
    pulses = $countones(reg_wr);
    if (do_check) sb_check();
    repeat (hold - 1) begin
      @(posedge clk_sys); #1;
      pulses += $countones(reg_wr);
    end
    ioctl_wr = 1'b0;
    @(posedge clk_sys); #1;
    pulses += $countones(reg_wr);
  endtask

  task automatic meas_fall(input string tag);
    int n;
    n = 0;
    while (n < 40) begin
      @(posedge clk_sys); #1;
      n++;
      if (!core_reset) break;
    end
    chk(tag, n, 17);
  endtask

  initial begin
    int p;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; status_reset = 1'b0;
    button_reset = 1'b0; ioctl_index = '0; ioctl_addr = '0; ioctl_dout = '0;
`ifdef ROM_LOADER_WAIT_EN
    ack_auto = 1'b1; ack_man = '0;
`endif
    model_rst();
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_req", reg_req, 0);
    chk("rst_wr", reg_wr, 0);
    chk("rst_core_mod", core_mod, 0);
    chk("rst_dip", dip, 0);
    chk("rst_rom_loaded", rom_loaded, 0);
    chk("rst_core_reset", core_reset, 1);
`ifdef ROM_LOADER_WAIT_EN
    chk("rst_wait", ioctl_wait, 0);
`endif
    reset = 1'b0;
    @(posedge clk_sys); #1;

    // ROM download: overlap, held strobe into pulse region, miss
    ioctl_download = 1'b1;
    wr_ev(8'd0, 25'h30001, 8'hA5, 1, 1, 1, p);
    wr_ev(8'd0, 25'h20010, 8'h3C, 5, 1, 1, p);
    chk("hold_one_pulse", p, 1);
    chk("pulse_rel", reg_addr_all[50 +: 25], 25'h10);
    chk("hold_req", reg_req, m.req);
    wr_ev(8'd0, 25'hA0000, 8'h33, 1, 1, 1, p);
    chk("still_resetting", core_reset, 1);
    ioctl_download = 1'b0;
    meas_fall("hold_after_dl");
    chk("rom_loaded", rom_loaded, 1);

    // Reload mid-count restarts the full hold
    status_reset = 1'b1; @(posedge clk_sys); #1; status_reset = 1'b0;
    repeat (8) @(posedge clk_sys);
    #1;
    chk("mid_count", core_reset, 1);
    status_reset = 1'b1; @(posedge clk_sys); #1; status_reset = 1'b0;
    meas_fall("hold_after_status");

    // Mode and DIP captures
    ioctl_download = 1'b1;
    wr_ev(8'd1, 25'h0, 8'h0B, 1, 1, 1, p);
    wr_ev(8'd254, 25'h3, 8'h5A, 1, 1, 1, p);
    chk("dip3", dip[31:24], 8'h5A);
    wr_ev(8'd254, 25'h9, 8'h77, 1, 1, 1, p);
    wr_ev(8'd254, 25'h7, 8'hC3, 1, 1, 1, p);
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;

    // Reset mid-download with wr held high
    ioctl_download = 1'b1; ioctl_index = 8'd0; ioctl_addr = 25'h30001;
    ioctl_dout = 8'hEE; ioctl_wr = 1'b1; reset = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    model_rst();
    chk("mid_rst_req", reg_req, 0);
    chk("mid_rst_dip", dip, 0);
    chk("mid_rst_loaded", rom_loaded, 0);
    chk("mid_rst_core_reset", core_reset, 1);
    reset = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    chk("no_spurious_req", reg_req, 0);
    chk("no_spurious_data", reg_data, 0);
    ioctl_wr = 1'b0;
    @(posedge clk_sys); #1;
    wr_ev(8'd0, 25'h30002, 8'h66, 1, 1, 1, p);

`ifdef ROM_LOADER_WAIT_EN
    ack_man = reg_req; ack_auto = 1'b0;
    wr_ev(8'd0, 25'h30001, 8'hA5, 1, 1, 1, p);
    chk("wait_hi", ioctl_wait, 1);
    wr_ev(8'd0, 25'h40000, 8'h11, 1, 1, 0, p);
    chk("pend_held_data", reg_data, 8'hA5);
    chk("ovf_clear", dut.ovf, 0);
    wr_ev(8'd0, 25'h50000, 8'h22, 1, 0, 0, p);
    chk("ovf_set", dut.ovf, 1);
    chk("wait_still_hi", ioctl_wait, 1);
    ack_man = reg_req;
    @(posedge clk_sys); #1;
    sb_check();
    ack_auto = 1'b1;
`endif

    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rom_loader_router.md
# rom_loader_router

Parametrised ROM-download router for arcade cores: snoops the HPS ioctl stream on `clk_sys` and fans each ROM byte out to N address regions. Each region is either an SDRAM port (toggle request) or a BRAM write strobe, with a region-relative address. It also captures the core-mode byte and DIP bytes. It generates the post-download core reset, replacing the hand-written download controller and reset counter in each core top level.

## Interface
Parameters:
- `NREG`, 4: number of output regions (1..8).
- `REG_BASE`, `{NREG{25'h0}}`: packed per-region inclusive base address.
- `REG_LIMIT`, `{NREG{25'h1FFFFFF}}`: packed per-region exclusive limit address.
- `REG_MODE`, 0: bit i = 0 selects toggle request (SDRAM); 1 selects single-cycle write pulse (BRAM).
- `DIP_BYTES`, 8: DIP bytes captured from index 254 (1..8).
- `RST_HOLD`, 16'hFFFF: core-reset hold count after the last reset cause.

Ports (one clock; reset is synchronous and active-high):
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous, active-high block reset.
- `ioctl_download` in 1: HPS download active.
- `ioctl_index` in 8: download index.
- `ioctl_wr` in 1: write strobe, level, possibly multi-cycle.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `status_reset` in 1: OSD reset.
- `button_reset` in 1: user button reset.
- `reg_req` out NREG: per-region toggle request, mode-0 regions only.
- `reg_wr` out NREG: per-region write pulse, mode-1 regions only.
- `reg_addr` out 25: address minus the hit region's base. When several regions hit, each consumer subtracts its own base; the `reg_addr_all` port carries this.
- `reg_addr_all` out 25*NREG: per-region relative address.
- `reg_data` out 8: latched byte.
- `core_mod` out 8: last byte written at index 1.
- `dip` out 8*DIP_BYTES: DIP byte k at bits [8k+7:8k].
- `rom_loaded` out 1: at least one ROM download completed.
- `core_reset` out 1: reset to the game core.
- `reg_ack` in NREG: ack toggles. Only present with `ROM_LOADER_WAIT_EN`.
- `ioctl_wait` out 1: stall to HPS. Only present with `ROM_LOADER_WAIT_EN`.

## Operation
- `rom_dl` = `ioctl_download` & (`ioctl_index` == 0).
- Write event = rising edge of `ioctl_wr`, sampled against a registered `wr_last`.
- **ROM event** (rom_dl):
  - Region i hits when `REG_BASE[i]` <= addr < `REG_LIMIT[i]`. Overlap is legal; every hit region fires.
  - Mode 0: `reg_req[i]` toggles.
  - Mode 1: `reg_wr[i]` pulses for 1 cycle.
  - `reg_addr_all[i]` <= addr − base (25-bit wrap, meaningful only on a hit).
  - `reg_data` <= dout.
  - No hit: no output changes except `reg_data`.
- **Index 1 event**: `core_mod` <= dout, regardless of addr.
- **Index 254 event** with addr < `DIP_BYTES`: `dip[addr]` <= dout. Higher addresses are ignored.
- **rom_loaded**: set on the falling edge of rom_dl; cleared only by `reset`.
- **Reset counter** (16 bit):
  - Loads `RST_HOLD` while `status_reset` | `button_reset` | ~`rom_loaded` | rom_dl.
  - Otherwise decrements to 0 and saturates.
  - `core_reset` <= (cnt != 0), registered.

## Timing
- Outputs change 1 cycle after the `ioctl_wr` rising-edge cycle. `reg_wr` is high for exactly that one cycle.
- A level-held `ioctl_wr` produces one event only.
- `core_reset` deasserts `RST_HOLD`+1 cycles after the last cause clears.
- Reset values:
  - `reg_req`, `reg_wr`, `core_mod`, `dip`, `rom_loaded` = 0.
  - `wr_last` = 1, so a `wr` held high through reset produces no event.
  - cnt = `RST_HOLD`; `core_reset` = 1; `ioctl_wait` = 0.
- `reset` mid-download: all state returns to reset values. The next write edge is processed normally.
- `ioctl_index` changing in the same cycle as a write edge: the index sampled in the edge cycle is used.

## Configuration
`ROM_LOADER_WAIT_EN` defined:
- A mode-0 region is outstanding while `reg_req[i]` != `reg_ack[i]`.
- `ioctl_wait` = 1 while any region is outstanding.
- A write edge arriving while outstanding is held in a one-entry pending slot (addr, data, index) and issued the cycle after `ioctl_wait` falls.
- A second edge while the slot is full is dropped and sets a sticky internal `ovf` flag, readable in simulation.

Undefined: no `reg_ack`/`ioctl_wait` ports and no pending slot. Requests are fire-and-forget.

## Structure
- Package `rom_loader_pkg`:
  - `IDX_ROM`=0, `IDX_MOD`=1, `IDX_DIP`=254.
  - `typedef enum logic {MODE_TOGGLE, MODE_PULSE} reg_mode_t`.
  - `ADDR_W`=25.
- Sub-module `rom_region_dec`: one instance per region via generate. Performs the base/limit compare and subtract, and owns that region's req/wr register.

## Test plan
- `NREG`=2, region0 [0,0x90000) toggle, region1 [0x30000,0x90000) toggle. Write 0x30001=0xA5 → both reqs toggle; `reg_addr_all` = 0x30001 / 0x00001; `reg_data`=0xA5.
- Mode-1 region [0x20000,0x30000). Hold `ioctl_wr` high 5 cycles at 0x20010 → exactly one `reg_wr` pulse, relative addr 0x10.
- Index 1 write 0x0B → `core_mod`=0x0B. Index 254 addr 3=0x5A → `dip[3]`=0x5A. Index 254 addr 9 with `DIP_BYTES`=8 → no change.
- `RST_HOLD`=16: end the download → `core_reset` falls 17 cycles later. Pulse `status_reset` mid-count → count reloads and the full hold repeats.
- `reset` asserted during a download with `wr` high → all outputs at reset values. Release with `wr` still high → no spurious event.
- `ROM_LOADER_WAIT_EN`: withhold ack, issue two edges → `ioctl_wait`=1, second held pending. Give ack → second req issues next cycle. A third edge while pending sets `ovf`.
